// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one downstream memory port between the instruction port
//            (A, read-only) and the data port (B, read/write), one request at
//            a time, with alternating priority under contention.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    read_a,
    input  logic [ADDR_WIDTH-1:0]   address_a,
    output logic [DATA_WIDTH-1:0]   rdata_a,
    output logic                    resp_a,

    input  logic                    read_b,
    input  logic                    write_b,
    input  logic [DATA_WIDTH/8-1:0] wmask_b,
    input  logic [ADDR_WIDTH-1:0]   address_b,
    input  logic [DATA_WIDTH-1:0]   wdata_b,
    output logic [DATA_WIDTH-1:0]   rdata_b,
    output logic                    resp_b,

    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [ADDR_WIDTH-1:0]   pmem_address,
    output logic [DATA_WIDTH-1:0]   pmem_wdata,
    output logic [DATA_WIDTH/8-1:0] pmem_wmask,
    input  logic [DATA_WIDTH-1:0]   pmem_rdata,
    input  logic                    pmem_resp
);

    localparam int MASK_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BUSY_A = 3'd1,
        S_BUSY_B = 3'd2,
        S_DONE_A = 3'd3,
        S_DONE_B = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_last_b;
    logic                    r_pmem_read;
    logic                    r_pmem_write;
    logic [ADDR_WIDTH-1:0]   r_pmem_address;
    logic [DATA_WIDTH-1:0]   r_pmem_wdata;
    logic [MASK_W-1:0]       r_pmem_wmask;
    logic [DATA_WIDTH-1:0]   r_rdata_a;
    logic [DATA_WIDTH-1:0]   r_rdata_b;
    logic                    r_resp_a;
    logic                    r_resp_b;

    logic                    w_req_b;
    logic                    w_grant_b;
    logic                    w_grant_a;

    // B wins ties unless it won the previous grant, giving strict alternation.
    assign w_req_b   = read_b | write_b;
    assign w_grant_b = w_req_b & (~read_a | ~r_last_b);
    assign w_grant_a = read_a & ~w_grant_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_last_b       <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_pmem_wmask   <= '0;
            r_rdata_a      <= '0;
            r_rdata_b      <= '0;
            r_resp_a       <= 1'b0;
            r_resp_b       <= 1'b0;
        end else begin
            r_resp_a <= 1'b0;
            r_resp_b <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_b) begin
                        r_pmem_address <= address_b;
                        r_pmem_wdata   <= wdata_b;
                        r_pmem_wmask   <= wmask_b;
                        // A simultaneous read+write request is served as a write.
                        r_pmem_write   <= write_b;
                        r_pmem_read    <= ~write_b;
                        r_last_b       <= 1'b1;
                        r_state        <= S_BUSY_B;
                    end else if (w_grant_a) begin
                        r_pmem_address <= address_a;
                        r_pmem_wdata   <= '0;
                        r_pmem_wmask   <= '0;
                        r_pmem_write   <= 1'b0;
                        r_pmem_read    <= 1'b1;
                        r_last_b       <= 1'b0;
                        r_state        <= S_BUSY_A;
                    end
                end
                S_BUSY_A: begin
                    if (pmem_resp) begin
                        r_rdata_a    <= pmem_rdata;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_resp_a     <= 1'b1;
                        r_state      <= S_DONE_A;
                    end
                end
                S_BUSY_B: begin
                    if (pmem_resp) begin
                        // Writes leave the load-data register untouched.
                        if (r_pmem_read) begin
                            r_rdata_b <= pmem_rdata;
                        end
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_resp_b     <= 1'b1;
                        r_state      <= S_DONE_B;
                    end
                end
                S_DONE_A: r_state <= S_IDLE;
                S_DONE_B: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign rdata_a      = r_rdata_a;
    assign resp_a       = r_resp_a;
    assign rdata_b      = r_rdata_b;
    assign resp_b       = r_resp_b;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign pmem_wmask   = r_pmem_wmask;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter with a word memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_a;
    logic [31:0] address_a;
    logic [31:0] rdata_a;
    logic        resp_a;
    logic        read_b;
    logic        write_b;
    logic [3:0]  wmask_b;
    logic [31:0] address_b;
    logic [31:0] wdata_b;
    logic [31:0] rdata_b;
    logic        resp_b;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_wmask;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .read_a(read_a), .address_a(address_a), .rdata_a(rdata_a), .resp_a(resp_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
        .wdata_b(wdata_b), .rdata_b(rdata_b), .resp_b(resp_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp)
    );

    initial forever #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void flag(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endfunction

    // ---------------- downstream memory model ----------------
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] v;
        v = mem_rd(a);
        for (int i = 0; i < 4; i++) if (m[i]) v[8*i +: 8] = d[8*i +: 8];
        mem[a] = v;
    endfunction

    int fixed_k = -1;
    bit spur_en = 1'b0;

    initial begin
        bit act;
        int wait_n;
        act = 1'b0;
        wait_n = 0;
        pmem_resp = 1'b0;
        pmem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (!(pmem_read || pmem_write)) begin
                act = 1'b0;
                pmem_rdata = $urandom;
                if (spur_en && $urandom_range(0, 7) == 0) pmem_resp = 1'b1;
            end else begin
                if (!act) begin
                    act = 1'b1;
                    wait_n = (fixed_k >= 0) ? fixed_k : int'($urandom_range(0, 4));
                end
                if (wait_n == 0) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        mem_wr(pmem_address, pmem_wdata, pmem_wmask);
                        pmem_rdata = $urandom;
                    end else begin
                        pmem_rdata = mem_rd(pmem_address);
                    end
                end else begin
                    wait_n--;
                    pmem_rdata = $urandom;
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct { bit port_b; bit wr; logic [31:0] data; } exp_t;
    typedef struct { bit port_b; int strobe_cycles; } log_t;
    exp_t sb[$];
    log_t glog[$];
    exp_t e;

    int          cyc = 0;
    int          resp_cyc = 0;
    int          strobe_cnt = 0;
    bit          txn_active = 1'b0;
    bit          got_resp = 1'b0;
    bit          cur_port_b = 1'b0;
    logic [31:0] cur_addr = '0;
    bit          strobe_now;
    bit          gb;
    bit          model_last_b = 1'b0;
    logic [31:0] hold_a = '0;
    logic [31:0] hold_b = '0;
    bit          hold_b_known = 1'b1;
    bit          rst_prev = 1'b0, pa_prev = 1'b0, pb_prev = 1'b0, wb_prev = 1'b0;
    logic [31:0] aa_prev = '0, ab_prev = '0, wd_prev = '0;
    logic [3:0]  wm_prev = '0;

    always @(negedge clk) begin
        cyc++;
        strobe_now = pmem_read | pmem_write;
        if (rst_prev) begin
            chk("reset_rdata", {rdata_a, rdata_b}, 64'h0);
            chk("reset_pmem_addr_data", {pmem_address, pmem_wdata}, 64'h0);
            chk("reset_ctl", {resp_a, resp_b, pmem_read, pmem_write, pmem_wmask}, 64'h0);
            sb.delete();
            txn_active = 1'b0;
            got_resp = 1'b0;
            model_last_b = 1'b0;
            hold_a = '0;
            hold_b = '0;
            hold_b_known = 1'b1;
        end else if (resp_a || resp_b) begin
            chk("resp_exclusive", {63'h0, resp_a & resp_b}, 64'h0);
            if (sb.size() == 0 || !txn_active || !got_resp) begin
                flag("unexpected_resp", $sformatf("resp_a=%0b resp_b=%0b with no completed transaction", resp_a, resp_b));
            end else begin
                e = sb.pop_front();
                chk("resp_port_b", {63'h0, resp_b}, {63'h0, e.port_b});
                chk("resp_latency", cyc, resp_cyc + 1);
                chk("strobe_released", {63'h0, strobe_now}, 64'h0);
                if (e.wr) begin
                    hold_b_known = 1'b0;
                end else if (e.port_b) begin
                    chk("rdata_b", rdata_b, e.data);
                    hold_b = e.data;
                    hold_b_known = 1'b1;
                end else begin
                    chk("rdata_a", rdata_a, e.data);
                    hold_a = e.data;
                end
            end
            txn_active = 1'b0;
            got_resp = 1'b0;
        end else begin
            chk("hold_rdata_a", rdata_a, hold_a);
            if (hold_b_known) chk("hold_rdata_b", rdata_b, hold_b);
            if (txn_active && got_resp) begin
                flag("missing_resp", "no resp one cycle after pmem_resp");
                if (sb.size() > 0) void'(sb.pop_front());
                txn_active = 1'b0;
                got_resp = 1'b0;
            end else if (txn_active && !strobe_now) begin
                flag("strobe_dropped", "pmem strobe fell before pmem_resp");
                if (sb.size() > 0) void'(sb.pop_front());
                txn_active = 1'b0;
            end
            if (!txn_active && strobe_now) begin
                if (!pa_prev && !pb_prev) begin
                    flag("spurious_grant", "pmem strobe with no pending request");
                end else begin
                    gb = pb_prev && (!pa_prev || !model_last_b);
                    model_last_b = gb;
                    cur_addr = gb ? ab_prev : aa_prev;
                    chk("grant_addr", pmem_address, cur_addr);
                    chk("pmem_write", {63'h0, pmem_write}, {63'h0, gb && wb_prev});
                    chk("pmem_read", {63'h0, pmem_read}, {63'h0, !(gb && wb_prev)});
                    if (gb && wb_prev) chk("pmem_wdata_wmask", {pmem_wdata, pmem_wmask}, {wd_prev, wm_prev});
                    e.port_b = gb;
                    e.wr = gb && wb_prev;
                    e.data = mem_rd(cur_addr);
                    sb.push_back(e);
                    cur_port_b = gb;
                    strobe_cnt = 0;
                    txn_active = 1'b1;
                end
            end
            if (txn_active && strobe_now && !got_resp) begin
                strobe_cnt++;
                chk("addr_stable", pmem_address, cur_addr);
                if (pmem_resp) begin
                    got_resp = 1'b1;
                    resp_cyc = cyc;
                    glog.push_back('{port_b: cur_port_b, strobe_cycles: strobe_cnt});
                end
            end
        end
        rst_prev = rst;
        pa_prev  = read_a;
        pb_prev  = read_b | write_b;
        wb_prev  = write_b;
        aa_prev  = address_a;
        ab_prev  = address_b;
        wd_prev  = wdata_b;
        wm_prev  = wmask_b;
    end

    // ---------------- stimulus ----------------
    task automatic wait_a(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_a && lat < 200);
        if (!resp_a) flag("timeout_a", $sformatf("no resp_a after %0d cycles, required one", lat));
        @(posedge clk); #1;
        read_a = 1'b0;
    endtask

    task automatic req_a(input logic [31:0] addr, output int lat);
        read_a = 1'b1;
        address_a = addr;
        wait_a(lat);
    endtask

    task automatic req_b(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] m, output int lat);
        read_b = rd; write_b = wr; address_b = addr; wdata_b = wd; wmask_b = m;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_b && lat < 200);
        if (!resp_b) flag("timeout_b", $sformatf("no resp_b after %0d cycles, required one", lat));
        @(posedge clk); #1;
        read_b = 1'b0;
        write_b = 1'b0;
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        flag("watchdog", "simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        rst = 1'b1;
        read_a = 1'b1; address_a = 32'h0000_0040;
        read_b = 1'b0; write_b = 1'b0; wmask_b = '0; address_b = '0; wdata_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_a(lat);
        idle(2);

        // single fetch with memory latency k=2
        fixed_k = 2;
        mem[32'h60] = 32'h0000_0013;
        glog.delete();
        req_a(32'h60, lat);
        chk("fetch_latency", lat - 1, 4);
        if (glog.size() == 1) chk("fetch_strobe_cycles", glog[0].strobe_cycles, 3);
        else flag("fetch_log", $sformatf("%0d grants logged, required 1", glog.size()));
        idle(2);

        // contention with k=0: both ports continuously requesting
        fixed_k = 0;
        glog.delete();
        fork
            begin
                int la;
                for (int i = 0; i < 4; i++) req_a(32'h0000_1000 + 32'(i * 4), la);
            end
            begin
                int lb;
                for (int i = 0; i < 4; i++) req_b(1'b1, 1'b0, 32'h8000_2000 + 32'(i * 4), 32'h0, 4'h0, lb);
            end
        join
        if (glog.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("grant_order_b", {63'h0, glog[i].port_b}, {63'h0, (i % 2) == 0});
        end else begin
            flag("contention_log", $sformatf("%0d grants logged, required 4+", glog.size()));
        end
        idle(2);

        // store, read back, then read+write conflict
        fixed_k = -1;
        req_b(1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011, lat);
        req_b(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, lat);
        req_b(1'b1, 1'b1, 32'h200, 32'h1234_5678, 4'hF, lat);
        req_a(32'h200, lat);
        idle(1);

        // reset in the middle of a B read
        fixed_k = 20;
        read_b = 1'b1;
        address_b = 32'h8000_0300;
        n = 0;
        do begin @(negedge clk); n++; end while (!pmem_read && n < 20);
        if (!pmem_read) flag("midop_start", "pmem_read never rose");
        @(posedge clk); #1;
        rst = 1'b1;
        read_b = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(6);
        fixed_k = -1;
        req_a(32'h0000_0060, lat);
        idle(2);

        // randomized traffic on both ports
        spur_en = 1'b1;
        fork
            begin
                int la, g;
                for (int i = 0; i < 40; i++) begin
                    g = $urandom_range(0, 3);
                    idle(g);
                    req_a(32'h100 + 32'($urandom_range(0, 15) * 4), la);
                end
            end
            begin
                int lb, g, op;
                for (int i = 0; i < 40; i++) begin
                    g = $urandom_range(0, 3);
                    idle(g);
                    op = $urandom_range(0, 3);
                    req_b(op != 2, op >= 2, 32'h100 + 32'($urandom_range(0, 15) * 4),
                          $urandom, 4'($urandom_range(0, 15)), lb);
                end
            end
        join
        spur_en = 1'b0;
        idle(5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Memory-side responder for the pipelined RV32I datapath's two memory ports. It serves the instruction port (A, read-only) and the data port (B, read/write with byte mask) from a single downstream memory port (pmem), one transaction at a time. It answers each CPU request with a one-cycle `resp` pulse carrying read data. It sits between the datapath and the L2/physical memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width of all ports.
- `DATA_WIDTH`, 32, data width of all ports. `wmask` width is `DATA_WIDTH/8`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `read_a` in 1: instruction read request. Held until `resp_a`.
- `address_a` in ADDR_WIDTH: instruction address.
- `rdata_a` out DATA_WIDTH: instruction data, valid while `resp_a`=1.
- `resp_a` out 1: one-cycle completion pulse for port A.
- `read_b` in 1: data read request. Held until `resp_b`.
- `write_b` in 1: data write request. Held until `resp_b`.
- `wmask_b` in DATA_WIDTH/8: byte enables for writes.
- `address_b` in ADDR_WIDTH: data address.
- `wdata_b` in DATA_WIDTH: write data.
- `rdata_b` out DATA_WIDTH: load data, valid while `resp_b`=1.
- `resp_b` out 1: one-cycle completion pulse for port B.
- `pmem_read` out 1: downstream read; held until `pmem_resp`.
- `pmem_write` out 1: downstream write; held until `pmem_resp`.
- `pmem_address` out ADDR_WIDTH: downstream address, registered.
- `pmem_wdata` out DATA_WIDTH: downstream write data, registered.
- `pmem_wmask` out DATA_WIDTH/8: downstream byte enables, registered.
- `pmem_rdata` in DATA_WIDTH: downstream read data, valid with `pmem_resp`.
- `pmem_resp` in 1: downstream completion.

## Operation
- States: IDLE, BUSY_A, BUSY_B, DONE_A, DONE_B.
- **IDLE**
  - Samples requests. `req_b = read_b | write_b`.
  - If `req_b` and `read_a` are both pending, the winner is B unless the `last_b` flag is set; then A wins.
  - Otherwise the single requester wins.
  - On grant, latch address, wdata and wmask into the pmem registers and the op type, then go to BUSY_x. `last_b` records the granted port.
- **BUSY_x**
  - `pmem_read` or `pmem_write` is driven from the registered op.
  - On `pmem_resp`=1: latch `pmem_rdata` into the port's rdata register, deassert pmem strobes on the next cycle, go to DONE_x.
- **DONE_x**
  - `resp_x`=1 for exactly one cycle with registered rdata, then IDLE.
  - Request inputs are ignored in DONE.
- `read_b` & `write_b` both asserted: treated as write.
- A-port write is impossible; port A is read-only.
- For writes, `rdata_b` during `resp_b` is don't-care. It is driven with the last latched value; no X.
- Request inputs change only after `resp`. The arbiter does not re-check them in BUSY; the latched copy is authoritative.
- `rdata_a`/`rdata_b` hold their last value between responses.
- **Reset**
  - All outputs 0; state IDLE; `last_b`=0; rdata registers 0.
  - Reset mid-transaction abandons it: pmem strobes drop the cycle after `rst` is sampled, and no `resp` is issued.
  - The downstream must tolerate an abandoned request.

## Timing
- Request visible in IDLE at cycle T → pmem strobe asserted in cycle T+1.
- `pmem_resp` at cycle T+1+k (k≥0) → `resp_x` in cycle T+2+k → IDLE at T+3+k.
- Minimum request-to-resp latency is 2 cycles. Back-to-back throughput is one transaction per 3 cycles plus memory latency.
- `pmem_resp` in the same cycle the strobe first rises is legal (k=0).
- `pmem_resp` outside BUSY is ignored.
- `resp_a` and `resp_b` are never asserted together.
- Starvation bound: with both ports continuously requesting, grants strictly alternate B, A, B, A….

## Test plan
- **Reset:** assert `rst` for 2 cycles with `read_a`=1 → all outputs 0. The first cycle after release is IDLE; `pmem_read`=1 one cycle later with `pmem_address`=`address_a`.
- **Single fetch:** `read_a`=1, `address_a`=0x60, memory returns 0x00000013 with k=2 → `pmem_read` high 3 cycles; `resp_a` pulses once, 4 cycles after request, with `rdata_a`=0x00000013.
- **Store:** `write_b`=1, `address_b`=0x104, `wdata_b`=0xDEADBEEF, `wmask_b`=4'b0011 → `pmem_write`=1 with identical registered values; one `resp_b` pulse; `resp_a` stays 0.
- **Contention:** `read_a` and `read_b` held continuously with k=0 → grant order B, A, B, A. Each `resp` follows 2 cycles after its grant, and no two `resp` pulses overlap.
- **Read+write conflict:** `read_b`=`write_b`=1 → `pmem_write`=1, `pmem_read`=0.
- **Reset mid-op:** assert `rst` during BUSY_B → `pmem_read` low the next cycle; no `resp_b`; a new `read_a` after release is served normally.
